// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays out an amount using 10/5/2/1 coins, one hopper handshake per coin.
// Optional hopper timeout/fault handling is enabled by defining CHANGE_TIMEOUT_EN.
module change_dispenser #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] amount,
  input  logic       coin_ack,
  input  logic       fault_clr,
  output logic       coin_req,
  output logic [3:0] coin_val,
  output logic [7:0] remaining,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EJECT,
    S_DONE,
    S_FAULT
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_remaining;
  logic [3:0] r_coin_val;
  logic       w_last_coin;

  function automatic logic [3:0] pick_coin(input logic [7:0] amt);
    if (amt >= 8'd10)     return 4'd10;
    else if (amt >= 8'd5) return 4'd5;
    else if (amt >= 8'd2) return 4'd2;
    else                  return 4'd1;
  endfunction

  assign w_last_coin = (r_remaining == {4'd0, r_coin_val});

`ifdef CHANGE_TIMEOUT_EN
  localparam logic [4:0] TIMER_LAST = 5'(TIMEOUT_CYCLES - 1);

  logic [4:0] r_timer;
  logic       w_timeout;

  assign w_timeout = (r_timer == TIMER_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= 5'd0;
    end else if (r_state == S_SELECT) begin
      r_timer <= 5'd0;
    end else if (r_state == S_EJECT && !coin_ack) begin
      r_timer <= r_timer + 5'd1;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = fault_clr ^ TIMEOUT_CYCLES[0];
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: w_next gets its default first so no path through the case infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (amount == 8'd0) ? S_DONE : S_SELECT;
      end
      S_SELECT: w_next = S_EJECT;
      S_EJECT: begin
        if (coin_ack) begin
          w_next = w_last_coin ? S_DONE : S_SELECT;
        end
`ifdef CHANGE_TIMEOUT_EN
        else if (w_timeout) begin
          w_next = S_FAULT;
        end
`endif
      end
      S_DONE: w_next = S_IDLE;
      S_FAULT: begin
`ifdef CHANGE_TIMEOUT_EN
        if (fault_clr) w_next = S_IDLE;
`else
        w_next = S_IDLE;
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Remaining is only ever reduced by a coin no larger than itself, so it cannot underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_remaining <= 8'd0;
      r_coin_val  <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE:   if (start) r_remaining <= amount;
        S_SELECT: r_coin_val <= pick_coin(r_remaining);
        S_EJECT:  if (coin_ack) r_remaining <= r_remaining - {4'd0, r_coin_val};
        default:  ;
      endcase
    end
  end

  assign coin_req  = (r_state == S_EJECT);
  assign coin_val  = r_coin_val;
  assign remaining = r_remaining;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
`ifdef CHANGE_TIMEOUT_EN
  assign fault     = (r_state == S_FAULT);
`else
  assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed and randomized payouts against a
// greedy-change reference model, with cycle-exact handshake and done timing.
module tb_change_dispenser;

  localparam int unsigned TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] amount;
  logic       coin_ack;
  logic       fault_clr;
  logic       coin_req;
  logic [3:0] coin_val;
  logic [7:0] remaining;
  logic       busy;
  logic       done;
  logic       fault;

  int n_pass  = 0;
  int n_total = 0;
  int exp_coins[$];

  always #5 clk = ~clk;

  change_dispenser #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .amount    (amount),
    .coin_ack  (coin_ack),
    .fault_clr (fault_clr),
    .coin_req  (coin_req),
    .coin_val  (coin_val),
    .remaining (remaining),
    .busy      (busy),
    .done      (done),
    .fault     (fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: count how many of each denomination fit, largest first.
  function automatic void make_coins(input int amt);
    int denoms[4] = '{10, 5, 2, 1};
    int rem = amt;
    exp_coins.delete();
    foreach (denoms[k]) begin
      for (int n = 0; n < rem / denoms[k]; n++) exp_coins.push_back(denoms[k]);
      rem = rem % denoms[k];
    end
  endfunction

  // Called at a falling edge; start is sampled on the next rising edge.
  // delay < 0 picks a random ack delay (0..3 cycles) per coin.
  task automatic run_payout(input int amt, input int delay, input bit hold_ack, input bit poke);
    int rem = amt;
    int c;
    int d;
    make_coins(amt);
    amount   = 8'(amt);
    start    = 1'b1;
    coin_ack = hold_ack;
    @(negedge clk);
    start  = 1'b0;
    amount = 8'($urandom);
    foreach (exp_coins[i]) begin
      c = exp_coins[i];
      check("select_req", coin_req, 0);
      check("select_rem", remaining, rem);
      check("select_busy", busy, 1);
      @(negedge clk);
      check("eject_req", coin_req, 1);
      check("eject_val", coin_val, c);
      check("eject_rem", remaining, rem);
      if (poke && i == 0) begin
        start  = 1'b1;
        amount = 8'd99;
      end
      d = hold_ack ? 0 : (delay < 0 ? int'($urandom_range(0, 3)) : delay);
      for (int j = 0; j < d; j++) begin
        coin_ack = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("wait_req", coin_req, 1);
        check("wait_val", coin_val, c);
      end
      coin_ack = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (!hold_ack) coin_ack = 1'b0;
      rem -= c;
    end
    check("done_pulse", done, 1);
    check("done_rem", remaining, 0);
    check("done_req", coin_req, 0);
    check("done_busy", busy, 1);
    check("done_fault", fault, 0);
    @(negedge clk);
    coin_ack = 1'b0;
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    amount    = 8'd0;
    coin_ack  = 1'b0;
    fault_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", coin_req, 0);
    check("rst_val", coin_val, 0);
    check("rst_rem", remaining, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    rst = 1'b0;

    // First start honoured on the first edge after reset; 17 = 10+5+2 with ack held.
    run_payout(17, 0, 1'b1, 1'b0);
    // Zero amount: straight to a one-cycle done.
    run_payout(0, 0, 1'b0, 1'b0);
    // 9 = 5+2+2, coin_req visible for 3 cycles per coin.
    run_payout(9, 2, 1'b0, 1'b0);
    // start pulsed during EJECT must not disturb a 50 payout.
    run_payout(50, 1, 1'b0, 1'b1);
    // Ack arriving in IDLE is ignored.
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    check("idle_ack_busy", busy, 0);
    check("idle_ack_req", coin_req, 0);

    // Asynchronous reset in the middle of an EJECT.
    amount = 8'd30;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_req", coin_req, 1);
    check("pre_rst_rem", remaining, 30);
    #2 rst = 1'b1;
    #1;
    check("async_rst_req", coin_req, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_rem", remaining, 0);
    check("async_rst_val", coin_val, 0);
    @(negedge clk);
    rst = 1'b0;
    run_payout(1, 0, 1'b0, 1'b0);

    for (int r = 0; r < 12; r++) begin
      run_payout(int'($urandom_range(0, 120)), -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    run_payout(255, -1, 1'b0, 1'b0);

`ifdef CHANGE_TIMEOUT_EN
    // No ack: fault after exactly TIMEOUT coin_req cycles, remaining frozen.
    amount = 8'd4;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < int'(TIMEOUT); t++) begin
      @(negedge clk);
      check("to_req", coin_req, 1);
      check("to_nofault", fault, 0);
    end
    @(negedge clk);
    check("to_fault", fault, 1);
    check("to_rem", remaining, 4);
    check("to_req_off", coin_req, 0);
    check("to_busy", busy, 1);
    start  = 1'b1;
    amount = 8'd7;
    @(negedge clk);
    start = 1'b0;
    check("fault_hold", fault, 1);
    check("fault_rem_hold", remaining, 4);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("clr_fault", fault, 0);
    check("clr_busy", busy, 0);

    // Ack on the last permitted cycle wins over the timeout.
    amount = 8'd4;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < int'(TIMEOUT); t++) @(negedge clk);
    check("late_ack_req", coin_req, 1);
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    check("late_ack_fault", fault, 0);
    check("late_ack_rem", remaining, 2);
    @(negedge clk);
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    check("late_ack_done", done, 1);
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
